// File: rtl/alu_32bit.sv
// Registered 32-bit ALU: add/sub/and/or plus optional shifts, with compare and overflow flags.
// Define ALU_SHIFT_EN to include the barrel shifter (SLL/SRA); otherwise those opcodes return 0.
module alu_32bit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);

    typedef enum logic [4:0] {
        OP_ADD = 5'b00000,
        OP_SUB = 5'b00001,
        OP_AND = 5'b00010,
        OP_OR  = 5'b00011,
        OP_SLL = 5'b00100,
        OP_SRA = 5'b00101
    } alu_op_e;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic [31:0] w_result;
    logic        w_overflow;

    assign w_sum  = data_operandA + data_operandB;
    assign w_diff = data_operandA + ~data_operandB + 32'd1;

    assign w_add_ovf = (data_operandA[31] == data_operandB[31]) && (w_sum[31]  != data_operandA[31]);
    assign w_sub_ovf = (data_operandA[31] != data_operandB[31]) && (w_diff[31] != data_operandA[31]);

`ifdef ALU_SHIFT_EN
    logic [31:0] w_sll;
    logic [31:0] w_sra;

    assign w_sll = data_operandA << ctrl_shiftamt;
    assign w_sra = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
`else
    logic w_unused_shamt;

    assign w_unused_shamt = ^ctrl_shiftamt;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_result   = 32'd0;
        w_overflow = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                w_result   = w_sum;
                w_overflow = w_add_ovf;
            end
            OP_SUB: begin
                w_result   = w_diff;
                w_overflow = w_sub_ovf;
            end
            OP_AND: w_result = data_operandA & data_operandB;
            OP_OR:  w_result = data_operandA | data_operandB;
`ifdef ALU_SHIFT_EN
            OP_SLL: w_result = w_sll;
            OP_SRA: w_result = w_sra;
`endif
            default: ;
        endcase
    end

    // Flags come from the A-B subtractor regardless of opcode; XOR with overflow keeps
    // the signed less-than correct when the difference wraps.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: asynchronous reset clears outputs immediately; state uses non-blocking assignments.
        if (reset) begin
            data_result <= 32'd0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            data_result <= w_result;
            isNotEqual  <= |w_diff;
            isLessThan  <= w_diff[31] ^ w_sub_ovf;
            overflow    <= w_overflow;
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: behavioural model compared every cycle, plus literal cases.
module tb_alu_32bit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ovf;
    } exp_t;

    exp_t exp_q;

    alu_32bit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: signed math done in 64 bits, overflow = result not representable in 32.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] op, input logic [4:0] sh);
        exp_t   m;
        longint sa;
        longint sb;
        longint s;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        m.res = 32'd0;
        m.ovf = 1'b0;
        m.ne  = (a != b);
        m.lt  = (sa < sb);
        case (op)
            5'd0: begin
                s     = sa + sb;
                m.res = s[31:0];
                m.ovf = (s != longint'($signed(s[31:0])));
            end
            5'd1: begin
                s     = sa - sb;
                m.res = s[31:0];
                m.ovf = (s != longint'($signed(s[31:0])));
            end
            5'd2: m.res = a & b;
            5'd3: m.res = a | b;
`ifdef ALU_SHIFT_EN
            5'd4: m.res = a << sh;
            5'd5: m.res = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
`endif
            default: m.res = 32'd0;
        endcase
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) exp_q <= '0;
        else       exp_q <= model(data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt);
    end

    always @(negedge clock) begin
        check("cyc_result", data_result, exp_q.res);
        check("cyc_ne",     {31'd0, isNotEqual}, {31'd0, exp_q.ne});
        check("cyc_lt",     {31'd0, isLessThan}, {31'd0, exp_q.lt});
        check("cyc_ovf",    {31'd0, overflow},   {31'd0, exp_q.ovf});
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [4:0] sh);
        @(negedge clock);
        reset          = 1'b0;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_ALUopcode = op;
        ctrl_shiftamt  = sh;
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        reset          = 1'b1;
        data_operandA  = 32'hDEADBEEF;
        data_operandB  = 32'h12345678;
        ctrl_ALUopcode = 5'd1;
        ctrl_shiftamt  = 5'd3;
        #3;
        check("rst_result", data_result, 32'd0);
        check("rst_ne",  {31'd0, isNotEqual}, 32'd0);
        check("rst_lt",  {31'd0, isLessThan}, 32'd0);
        check("rst_ovf", {31'd0, overflow},   32'd0);

        drive(32'd3, 32'd4, 5'd0, 5'd0);
        settle();
        check("add_3_4", data_result, 32'h00000007);

        for (int i = 0; i <= 30; i++) begin
            a = 32'd1 << i;
            drive(a, a, 5'd0, 5'd0);
            settle();
            check("add_sweep", data_result, 32'd1 << (i + 1));
            check("add_sweep_ovf", {31'd0, overflow}, (i == 30) ? 32'd1 : 32'd0);
        end
        drive(32'hFFFFFFFF, 32'hFFFFFFFE, 5'd0, 5'd0);
        settle();
        check("add_neg", data_result, 32'hFFFFFFFD);
        check("add_neg_ovf", {31'd0, overflow}, 32'd0);

        drive(32'h80000001, 32'h00000001, 5'd1, 5'd0);
        settle();
        check("sub_min", data_result, 32'h80000000);
        for (int i = 0; i < 32; i++) begin
            a = 32'h11 << i;
            b = 32'h1 << i;
            drive(a, b, 5'd1, 5'd0);
            settle();
            check("sub_sweep", data_result, 32'h10 << i);
            a = 32'h80000001 << i;
            drive(a, a, 5'd1, 5'd0);
            settle();
            check("sub_self", data_result, 32'd0);
            check("sub_self_ne", {31'd0, isNotEqual}, 32'd0);
        end

        drive(32'h80000000, 32'h80000000, 5'd0, 5'd0);
        settle();
        check("ovf_add_min", data_result, 32'd0);
        check("ovf_add_min_f", {31'd0, overflow}, 32'd1);
        drive(32'h80000000, 32'h80000000, 5'd1, 5'd0);
        settle();
        check("ovf_sub_min", {31'd0, overflow}, 32'd0);
        drive(32'h80000000, 32'h0F000000, 5'd1, 5'd0);
        settle();
        check("ovf_sub_wrap", {31'd0, overflow}, 32'd1);

        drive(32'h0FFFFFFF, 32'hFFFFFFFF, 5'd2, 5'd0);
        settle();
        check("cmp_lt_pos", {31'd0, isLessThan}, 32'd0);
        check("cmp_ne_pos", {31'd0, isNotEqual}, 32'd1);
        drive(32'h80000001, 32'h7FFFFFFF, 5'd3, 5'd0);
        settle();
        check("cmp_lt_wrap", {31'd0, isLessThan}, 32'd1);
        drive(32'd0, 32'd0, 5'd0, 5'd0);
        settle();
        check("cmp_zero_lt", {31'd0, isLessThan}, 32'd0);
        check("cmp_zero_ne", {31'd0, isNotEqual}, 32'd0);

        drive(32'hFFFFFFFF, 32'd0, 5'd2, 5'd7);
        settle();
        check("and_zero", data_result, 32'd0);
        drive(32'd0, 32'hFFFFFFFF, 5'd3, 5'd7);
        settle();
        check("or_ones", data_result, 32'hFFFFFFFF);
        drive(32'd1, 32'hFFFFFFFF, 5'd4, 5'd24);
        settle();
`ifdef ALU_SHIFT_EN
        check("sll_24", data_result, 32'h01000000);
`else
        check("sll_off", data_result, 32'd0);
`endif
        drive(32'h80000000, 32'h12345678, 5'd5, 5'd4);
        settle();
`ifdef ALU_SHIFT_EN
        check("sra_4", data_result, 32'hF8000000);
`else
        check("sra_off", data_result, 32'd0);
`endif
        drive(32'h12345678, 32'h1, 5'd9, 5'd2);
        settle();
        check("undef_op", data_result, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            drive(rand_operand(), rand_operand(),
                  ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5)),
                  5'($urandom_range(0, 31)));
        end

        drive(32'd5, 32'd6, 5'd0, 5'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_result", data_result, 32'd0);
        check("mid_rst_ne", {31'd0, isNotEqual}, 32'd0);
        check("mid_rst_lt", {31'd0, isLessThan}, 32'd0);
        drive(32'hFFFFFFFF, 32'd1, 5'd1, 5'd0);
        settle();
        check("post_rst_sub", data_result, 32'hFFFFFFFE);
        check("post_rst_lt", {31'd0, isLessThan}, 32'd1);

        for (int n = 0; n < 200; n++) begin
            drive(rand_operand(), rand_operand(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        @(negedge clock);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
